// File: rtl/dm_access_pkg.sv
// dm_access_pkg: size encodings, controller states and default memory geometry
package dm_access_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;
endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: load lane extraction/extension and store read-modify-write merge
module dm_lane_unit import dm_access_pkg::*; (
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] bmask;
  always_comb begin
    sh = {off, 3'b000};
    b = 8'(word >> sh);
    h = off[1] ? word[31:16] : word[15:0];
    bmask = 32'hff << sh;
    rdata = size == SZ_BYTE ? {{24{sgn & b[7]}}, b}
          : size == SZ_HALF ? {{16{sgn & h[15]}}, h} : word;
    merged = size == SZ_BYTE ? (word & ~bmask) | ({24'b0, wdata[7:0]} << sh)
           : size == SZ_HALF ? (off[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]})
           : wdata;
  end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: CPU load/store controller for a word-wide synchronous-read data memory.
// Define DM_ACCESS_TRACE_EN to print a trace line for every memory write.
module dm_access_ctrl import dm_access_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  state_t      state;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [1:0]  size_q;
  logic        sgn_q, we_q, bad;
  logic [31:0] ext_rdata, merged;
  logic        unused_ok;
  assign req_ready = state == IDLE;
  assign bad = req_size == 2'b11 || (req_size == SZ_HALF && req_addr[0])
            || (req_size == SZ_WORD && |req_addr[1:0]) || |(req_addr >> (ADDR_W + 2));
  assign unused_ok = ^{pc_q, addr_q};
  dm_lane_unit u_lane (
    .word(mem_rdata), .wdata(wdata_q), .off(addr_q[1:0]), .size(size_q), .sgn(sgn_q),
    .rdata(ext_rdata), .merged(merged)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      pc_q <= '0;
      size_q <= '0;
      sgn_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          pc_q <= req_pc;
          size_q <= req_size;
          sgn_q <= req_signed;
          we_q <= req_we;
          if (bad) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            mem_addr <= req_addr[ADDR_W+1:2];
            mem_en <= 1'b1;
            // whole-word stores skip the read; sub-word stores read first to merge
            if (req_we && req_size == SZ_WORD) begin
              state <= WR;
              mem_we <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state <= RD;
              mem_we <= 1'b0;
            end
          end
        end
        RD: begin
          state <= WAIT;
          mem_en <= 1'b0;
        end
        WAIT: if (we_q) begin
          state <= WR;
          mem_en <= 1'b1;
          mem_we <= 1'b1;
          mem_wdata <= merged;
        end else begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_rdata <= ext_rdata;
        end
        WR: begin
          state <= RESP;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_rdata <= '0;
        end
        RESP: begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef DM_ACCESS_TRACE_EN
  always @(posedge clk)
    if (mem_en && mem_we) $display("@%08h: *%08h <= %08h", pc_q, 32'(mem_addr) << 2, mem_wdata);
`endif
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed and random load/store traffic against a byte-level memory model
module tb_dm_access_ctrl;
  logic        clk = 0;
  logic        reset = 0;
  logic        req_valid = 0, req_we = 0, req_signed = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, req_pc = 0;
  logic        req_ready, rsp_valid, rsp_err, mem_en, mem_we;
  logic [31:0] rsp_rdata, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [9:0]  mem_addr;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int          checks = 0, failures = 0;
  int          en_cnt = 0, wr_cnt = 0, rsp_cnt = 0;
  logic [9:0]  last_waddr = 0;

  dm_access_ctrl #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_pc(req_pc), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      en_cnt++;
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        last_waddr <= mem_addr;
        wr_cnt++;
      end else mem_rdata <= mem[mem_addr];
    end
    if (rsp_valid) rsp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int nb, input logic sgn);
    logic [31:0] mask, v;
    mask = nb == 4 ? 32'hffffffff : (32'h1 << (8 * nb)) - 1;
    v = (ref_mem[addr[11:2]] >> (8 * addr[1:0])) & mask;
    if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input int nb, input logic [31:0] wdata);
    logic [31:0] w;
    w = ref_mem[addr[11:2]];
    for (int i = 0; i < nb; i++) w[8*(addr[1:0]+i) +: 8] = wdata[8*i +: 8];
    ref_mem[addr[11:2]] = w;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc,
                        output logic [31:0] rd);
    int nb, cyc, exp_lat, en0, wr0;
    logic err;
    logic [31:0] exp_rd;
    nb = 1 << size;
    err = size == 2'b11 || (addr % nb) != 0 || addr >= 32'h1000;
    exp_rd = 0;
    if (!err && !we) exp_rd = ref_load(addr, nb, sgn);
    if (!err && we) ref_store(addr, nb, wdata);
    exp_lat = err ? 1 : !we ? 3 : nb == 4 ? 2 : 4;
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 1);
    en0 = en_cnt;
    wr0 = wr_cnt;
    req_valid = 1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_pc = pc;
    @(posedge clk);
    #1 req_valid = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 8);
    rd = rsp_rdata;
    check("latency", cyc, exp_lat);
    check("rsp_err", 32'(rsp_err), 32'(err));
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("mem_en_count", en_cnt - en0, err ? 0 : (we && nb < 4) ? 2 : 1);
    check("write_count", wr_cnt - wr0, (!err && we) ? 1 : 0);
    if (!err && we) begin
      check("write_addr", 32'(last_waddr), 32'(addr[11:2]));
      check("mem_word", mem[addr[11:2]], ref_mem[addr[11:2]]);
    end
    @(negedge clk);
    check("rsp_pulse", 32'(rsp_valid), 0);
  endtask

  initial begin
    logic [31:0] rd, keep;
    int rs0, wr0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    reset = 1;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ready", 32'(req_ready), 1);
    reset = 0;

    do_req(1, 2'b10, 0, 32'h10, 32'h12345678, 32'h100, rd);
    check("sw_word4", mem[4], 32'h12345678);
    do_req(0, 2'b10, 0, 32'h10, 0, 32'h104, rd);
    check("lw", rd, 32'h12345678);
    do_req(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h108, rd);
    do_req(1, 2'b00, 0, 32'h12, 32'h000000ab, 32'h10c, rd);
    check("sb_merge", mem[4], 32'h11ab3344);
    do_req(0, 2'b00, 1, 32'h12, 0, 32'h110, rd);
    check("lb", rd, 32'hffffffab);
    do_req(0, 2'b00, 0, 32'h12, 0, 32'h114, rd);
    check("lbu", rd, 32'h000000ab);
    do_req(1, 2'b10, 0, 32'h14, 32'h0, 32'h118, rd);
    do_req(1, 2'b01, 0, 32'h16, 32'h00008001, 32'h11c, rd);
    check("sh_merge", mem[5], 32'h80010000);
    do_req(0, 2'b01, 1, 32'h16, 0, 32'h120, rd);
    check("lh", rd, 32'hffff8001);
    do_req(0, 2'b01, 0, 32'h16, 0, 32'h124, rd);
    check("lhu", rd, 32'h00008001);
    do_req(0, 2'b10, 0, 32'h13, 0, 32'h128, rd);
    do_req(1, 2'b01, 0, 32'h11, 32'hffff, 32'h12c, rd);
    do_req(0, 2'b11, 0, 32'h10, 0, 32'h130, rd);
    do_req(0, 2'b10, 0, 32'h1000, 0, 32'h134, rd);
    do_req(1, 2'b10, 0, 32'h20, 32'hdeadbeef, 32'h3000, rd);

    // reset while a byte store sits in WAIT: nothing may be written or answered
    keep = mem[4];
    wr0 = wr_cnt;
    rs0 = rsp_cnt;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'b00; req_signed = 0;
    req_addr = 32'h12; req_wdata = 32'hcd; req_pc = 32'h200;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #2 reset = 1;
    #1 check("abort_wait_mem_en", 32'(mem_en), 0);
    check("abort_wait_ready", 32'(req_ready), 1);
    @(negedge clk) reset = 0;
    repeat (6) @(negedge clk);
    check("abort_no_write", wr_cnt - wr0, 0);
    check("abort_no_rsp", rsp_cnt - rs0, 0);
    check("abort_word_kept", mem[4], keep);
    check("abort_ready", 32'(req_ready), 1);

    // reset while a load read is on the bus: mem_en must drop without a clock edge
    rs0 = rsp_cnt;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 0;
    check("rd_mem_en", 32'(mem_en), 1);
    #2 reset = 1;
    #1 check("abort_rd_mem_en", 32'(mem_en), 0);
    @(negedge clk) reset = 0;
    repeat (4) @(negedge clk);
    check("abort_rd_no_rsp", rsp_cnt - rs0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [1:0] sz;
      a = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 63));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0 && sz != 2'b11) a = a & ~((32'h1 << sz) - 1);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
